// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clkdiv_ctrl_pkg;

  localparam int DIV_W   = 8;
  localparam int MIN_DIV = 2;

  typedef logic [DIV_W-1:0] div_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clkdiv_ctrl_core.sv
// Period counter with registered clk_out/tick; runs while 'run' is high and
// reports the last cycle of each period on 'wrap'.
module clkdiv_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic             active;

  always_comb begin
    wrap     = active && (cnt == div - DIV_W'(1));
    cnt_next = '0;
    if (run && active && !wrap) cnt_next = cnt + DIV_W'(1);
  end

  // A new div only ever lands with cnt_next==0, where clk_out is high for any legal ratio.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      active  <= run;
      cnt     <= cnt_next;
      clk_out <= run && (cnt_next < (div >> 1));
      tick    <= run && (cnt_next == '0);
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock-divider controller: start/stop FSM, glitch-free ratio updates via a
// shadow register. Optional completed-period counter: CLKDIV_CTRL_PERIOD_CNT_EN.
//
// state | meaning
// IDLE  | divider stopped, clk_out low, ratio writes apply immediately
// RUN   | divider running, en high
// DRAIN | en dropped, finishing the current period before stopping
module clkdiv_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic [15:0]      per_cnt
);

  import clkdiv_ctrl_pkg::*;

  state_e           state;
  state_e           state_next;
  logic             wrap;
  logic             xfer;
  logic             legal;
  logic             shadow_vld;
  logic [DIV_W-1:0] shadow;
  logic             div_wr;
  logic [DIV_W-1:0] div_new;
  logic             to_shadow;

  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = cfg_div >= DIV_W'(MIN_DIV);
  assign to_shadow = xfer && legal && (state != IDLE) && !wrap;

  // en high always keeps the divider going, even on the last cycle of a drain.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = wrap ? IDLE : DRAIN;
      DRAIN:   if (en) state_next = RUN;
               else if (wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    div_wr  = 1'b0;
    div_new = shadow;
    if (wrap && shadow_vld) begin
      div_wr = 1'b1;
    end else if (xfer && legal && ((state == IDLE) || wrap)) begin
      div_wr  = 1'b1;
      div_new = cfg_div;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      cur_div    <= DIV_W'(DEF_DIV);
      shadow     <= '0;
      shadow_vld <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != IDLE);
      cfg_err <= xfer && !legal;
      if (div_wr) cur_div <= div_new;
      if (to_shadow) begin
        shadow     <= cfg_div;
        shadow_vld <= 1'b1;
        cfg_ready  <= 1'b0;
      end else if (wrap) begin
        shadow_vld <= 1'b0;
        cfg_ready  <= 1'b1;
      end
    end
  end

  clkdiv_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .run    (state_next != IDLE),
    .div    (cur_div),
    .wrap   (wrap),
    .clk_out(clk_out),
    .tick   (tick)
  );

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [15:0] per_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
    end else if (div_wr) begin
      per_cnt_q <= '0;
    end else if (wrap && (per_cnt_q != 16'hFFFF)) begin
      per_cnt_q <= per_cnt_q + 16'd1;
    end
  end

  assign per_cnt = per_cnt_q;
`else
  assign per_cnt = '0;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios plus random en/config
// traffic, compared each cycle against a period-level reference model.
module tb_clkdiv_ctrl;

  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [DIV_W-1:0] cur_div;
  logic [15:0]      per_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: running flag, position within the period, period length,
  // one pending ratio slot, error pulse and completed-period count.
  bit m_act;
  int m_pos;
  int m_d;
  bit m_pend;
  int m_pval;
  bit m_err;
  int m_pc;

  clkdiv_ctrl #(
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy),
    .cur_div  (cur_div),
    .per_cnt  (per_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_pos  = 0;
    m_d    = DEF_DIV;
    m_pend = 1'b0;
    m_pval = 0;
    m_err  = 1'b0;
    m_pc   = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit last;
    bit rdy;
    bit upd;
    int nd;
    last  = m_act && (m_pos == m_d - 1);
    rdy   = !m_pend;
    upd   = 1'b0;
    nd    = m_d;
    m_err = 1'b0;
    if (v && rdy) begin
      if (d < 2) m_err = 1'b1;
      else if (!m_act || last) begin
        upd = 1'b1;
        nd  = d;
      end else begin
        m_pend = 1'b1;
        m_pval = d;
      end
    end
    if (last && !rdy) begin
      upd    = 1'b1;
      nd     = m_pval;
      m_pend = 1'b0;
    end
    if (m_act) begin
      m_pos = last ? 0 : m_pos + 1;
      if (last && !e) m_act = 1'b0;
    end else if (e) begin
      m_act = 1'b1;
      m_pos = 0;
    end
    if (upd) m_pc = 0;
    else if (last && m_pc < 65535) m_pc++;
    m_d = nd;
  endtask

  task automatic check_all();
    int exp_pc;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    exp_pc = m_pc;
`else
    exp_pc = 0;
`endif
    chk("clk_out",   32'(clk_out),   32'(m_act && (m_pos < m_d / 2)));
    chk("tick",      32'(tick),      32'(m_act && (m_pos == 0)));
    chk("busy",      32'(busy),      32'(m_act));
    chk("cur_div",   32'(cur_div),   32'(m_d));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("cfg_err",   32'(cfg_err),   32'(m_err));
    chk("per_cnt",   32'(per_cnt),   32'(exp_pc));
  endtask

  task automatic cycle(input bit e, input bit v, input int d);
    en        = e;
    cfg_valid = v;
    cfg_div   = DIV_W'(d);
    @(posedge clk);
    model_step(e, v, d);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_clk_out",   32'(clk_out),   32'(0));
    chk("rst_tick",      32'(tick),      32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_cur_div",   32'(cur_div),   32'(DEF_DIV));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
    chk("rst_cfg_err",   32'(cfg_err),   32'(0));
    chk("rst_per_cnt",   32'(per_cnt),   32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 300 && !(m_act && m_pos == k); i++) cycle(1, 0, 0);
    chk("run_to_pos", 32'(m_act && m_pos == k), 32'(1));
  endtask

  initial begin
    bit en_r;
    model_reset();
    @(negedge clk);
    do_reset();

    // Default ratio waveform, then a shadowed change to 6.
    for (int i = 0; i < 12; i++) cycle(1, 0, 0);
    run_to(1);
    cycle(1, 1, 6);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0);
    run_to(2);
    cycle(1, 1, 4);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);

    // Change accepted on the wrap cycle bypasses the shadow.
    run_to(3);
    cycle(1, 1, 3);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0);

    // Illegal ratios, then back to 4.
    run_to(1);
    cycle(1, 1, 1);
    cycle(1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    run_to(2);
    cycle(1, 1, 4);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);

    // Stop mid-period, then a drain cancelled by en coming back.
    run_to(1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    run_to(1);
    cycle(0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);

    // Pending ratio discarded by a mid-period reset.
    run_to(1);
    cycle(1, 1, 8);
    cycle(1, 0, 0);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);

    // Random traffic, including illegal ratios and occasional resets.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) en_r = !en_r;
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(en_r, $urandom_range(0, 4) == 0, int'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Runtime-programmable clock-divider controller. It generates a divided clock and a period tick from the system clock, with divide ratio D loaded over a valid/ready config port. It starts and stops the divider cleanly and applies new ratios only at period boundaries, so clk_out never glitches. It replaces fixed-N dividers wherever software or an upstream sequencer must change the ratio on the fly.

Parameters:
DIV_W, 8, width of divide-ratio field; legal D is 2..2^DIV_W-1
DEF_DIV, 4, divide ratio loaded at reset; must be 2..2^DIV_W-1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
en  input  1  level; 1 = run divider, 0 = stop at end of current period
cfg_valid  input  1  config request
cfg_div  input  DIV_W  requested divide ratio D
cfg_ready  output  1  config can be accepted this cycle
cfg_err  output  1  one-cycle pulse: accepted cfg_div < 2, discarded
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse on first cycle of each period
busy  output  1  state != IDLE
cur_div  output  DIV_W  ratio currently in effect
per_cnt  output  16  completed-period count (optional feature, else 0)

Behaviour:
- Reset, async on rst=1: state=IDLE, cnt=0, clk_out=0, tick=0, cfg_err=0, busy=0, cur_div=DEF_DIV, shadow_vld=0, cfg_ready=1, per_cnt=0. Reset mid-operation discards any pending config.
- Internal cnt, DIV_W bits, range 0..cur_div-1. half = cur_div>>1 (floor).
- All outputs are flops. clk_out_next = (cnt_next < half). tick_next = (cnt_next==0) and state_next != IDLE.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: cnt=0, clk_out=0, tick=0. Edge with en=1 -> RUN, cnt=0, clk_out=1, tick=1.
  - RUN: cnt_next = (cnt==cur_div-1) ? 0 : cnt+1. en=0 sampled -> DRAIN, counter still advances that edge. If en=0 is sampled when cnt==cur_div-1 -> IDLE directly.
  - DRAIN: counter advances. Edge with cnt==cur_div-1 -> IDLE (cnt=0, clk_out=0, tick=0). en=1 sampled in DRAIN -> RUN with no disturbance to cnt or clk_out.
- Wrap edge = edge where cnt==cur_div-1 in RUN or DRAIN.
- Config handshake: transfer when cfg_valid & cfg_ready.
  - In IDLE: cur_div <= cfg_div at that edge.
  - In RUN/DRAIN on a non-wrap cycle: cfg_div goes to shadow, shadow_vld=1, cfg_ready=0. At the next wrap edge: cur_div <= shadow, shadow_vld=0, cfg_ready=1 from the following cycle.
  - Accepted on the wrap cycle itself: bypasses shadow; cur_div <= cfg_div at that wrap edge.
  - cfg_ready = !shadow_vld. A pending value is never overwritten.
- Illegal cfg_div (0 or 1): handshake completes, cfg_err=1 next cycle for one cycle, cur_div and shadow unchanged.
- Example D=4 waveform: cnt 0,1,2,3 gives clk_out 1,1,0,0. Example D=5: 1,1,0,0,0.
- Latency: en rise to first clk_out high = 1 edge. A new ratio affects the period that starts after the wrap edge.

Optional Feature:
CLKDIV_CTRL_PERIOD_CNT_EN
- Defined: per_cnt increments at every wrap edge, saturating at 16'hFFFF. It clears to 0 at any edge where cur_div is updated.
- Undefined: no counter logic; per_cnt tied to 0.

Decomposition:
- Package clkdiv_ctrl_pkg: state_e enum (IDLE, RUN, DRAIN), localparam MIN_DIV=2, div_t typedef logic [DIV_W-1:0] with DIV_W default 8.
- Sub-module clkdiv_core: counter plus clk_out/tick generation, with inputs run, div, and output wrap. clkdiv_ctrl holds FSM, shadow register, handshake and the optional counter.

Test Plan:
- rst pulse, DEF_DIV=4, en=1 -> clk_out 1,1,0,0 repeating; tick every 4th cycle starting 1 edge after en; cur_div=4; busy=1.
- Running D=4, cfg_div=6 accepted at cnt=1 -> cfg_ready=0 until wrap; cur_div=6 after wrap; next period clk_out 1,1,1,0,0,0.
- Running D=4, cfg_div=3 accepted at cnt=3 -> no shadow use; next period clk_out 1,0,0; cfg_ready stays 1.
- cfg_div=1 in RUN -> cfg_err one cycle; cur_div unchanged; waveform undisturbed.
- D=4, en=0 at cnt=1 -> DRAIN; cnt 2,3 complete, then IDLE with clk_out=0, busy=0. Repeat, re-asserting en at cnt=2 -> stays RUN, period unbroken.
- Pending cfg 8 with shadow_vld=1, assert rst mid-period -> all outputs immediately at reset values, cur_div=4; pending value never applied.
